// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative signed shift-add multiply / restoring divide for the
//            ALU MUL and DIV opcodes; the {HI,LO} result is held on C_reg.
// Option   : MULDIV_EARLY_EXIT_EN - MUL finishes once the multiplier bits
//            still to be consumed are all zero.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int         WIDTH  = 32,
  parameter logic [4:0] OP_MUL = 5'b01110,
  parameter logic [4:0] OP_DIV = 5'b01111
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] C_reg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd, opnd_nxt;
  logic               is_div, is_div_nxt;
  logic               sign_q, sign_q_nxt;
  logic               sign_r, sign_r_nxt;
  logic               dz, dz_nxt;
  logic [2*WIDTH-1:0] c_nxt;
  logic               dbz_nxt;
  logic               done_nxt;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] mul_shift, div_step, fix_result;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               last_iter;

`ifdef MULDIV_EARLY_EXIT_EN
  logic [WIDTH-1:0]   mplr, mplr_nxt;
`endif

  assign a_mag     = A[WIDTH-1] ? -A : A;
  assign b_mag     = B[WIDTH-1] ? -B : B;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // Multiplier lives in acc low half; upper half accumulates with carry-out.
  assign mul_sum   = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                            : {1'b0, acc[2*WIDTH-1:WIDTH]};
  assign mul_shift = {mul_sum, acc[WIDTH-1:1]};

  // {rem,quo} in acc; trial-subtract the shifted remainder.
  assign div_diff  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  assign div_step  = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign quo_fix    = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix    = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  // Zero-divisor DIV preloads acc with {A, all-ones}, so it passes straight through.
  assign fix_result = !is_div ? (sign_q ? -acc : acc)
                    : (dz ? acc : {rem_fix, quo_fix});

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      C_reg       <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
      mplr        <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      acc         <= acc_nxt;
      opnd        <= opnd_nxt;
      is_div      <= is_div_nxt;
      sign_q      <= sign_q_nxt;
      sign_r      <= sign_r_nxt;
      dz          <= dz_nxt;
      C_reg       <= c_nxt;
      div_by_zero <= dbz_nxt;
      done        <= done_nxt;
`ifdef MULDIV_EARLY_EXIT_EN
      mplr        <= mplr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    opnd_nxt   = opnd;
    is_div_nxt = is_div;
    sign_q_nxt = sign_q;
    sign_r_nxt = sign_r;
    dz_nxt     = dz;
    c_nxt      = C_reg;
    dbz_nxt    = div_by_zero;
    done_nxt   = 1'b0;
    busy       = 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
    mplr_nxt   = mplr;
`endif

    case (state)
      S_IDLE: begin
        if (start && opcode == OP_MUL) begin
          state_nxt  = S_MUL;
          cnt_nxt    = '0;
          acc_nxt    = {{WIDTH{1'b0}}, b_mag};
          opnd_nxt   = a_mag;
          is_div_nxt = 1'b0;
          sign_q_nxt = A[WIDTH-1] ^ B[WIDTH-1];
          sign_r_nxt = 1'b0;
          dz_nxt     = 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
          mplr_nxt   = b_mag;
`endif
        end else if (start && opcode == OP_DIV) begin
          state_nxt  = S_DIV;
          cnt_nxt    = '0;
          opnd_nxt   = b_mag;
          is_div_nxt = 1'b1;
          sign_q_nxt = A[WIDTH-1] ^ B[WIDTH-1];
          sign_r_nxt = A[WIDTH-1];
          dz_nxt     = (B == '0);
          acc_nxt    = (B == '0) ? {A, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_mag};
        end
      end
      S_MUL: begin
        busy    = 1'b1;
        acc_nxt = mul_shift;
        cnt_nxt = cnt + CW'(1);
        if (last_iter) state_nxt = S_FIX;
`ifdef MULDIV_EARLY_EXIT_EN
        mplr_nxt = mplr >> 1;
        if (mplr_nxt == '0) begin
          acc_nxt   = mul_shift >> (CW'(WIDTH - 1) - cnt);
          state_nxt = S_FIX;
        end
`endif
      end
      S_DIV: begin
        busy = 1'b1;
        if (dz) begin
          state_nxt = S_FIX;
        end else begin
          acc_nxt = div_step;
          cnt_nxt = cnt + CW'(1);
          if (last_iter) state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        busy      = 1'b1;
        c_nxt     = fix_result;
        dbz_nxt   = is_div & dz;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        // done is registered out of DONE so the pulse comes straight from a flop.
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
